// File: rtl/profiler_pkg.sv
// rtl/profiler_pkg.sv - shared types and constants for the profiler run-control block
//
// Purpose: command and state encodings, counter count and counter index map
// shared by the controller, its stream stage and anything that decodes
// the snapshot stream.
package profiler_pkg;

    localparam int NUM_PROF_COUNTERS = 11;

    // Position of each counter on the flat counter bus and in the snapshot stream.
    localparam int IDX_LOAD    = 0;
    localparam int IDX_STORE   = 1;
    localparam int IDX_ADD     = 2;
    localparam int IDX_SUB     = 3;
    localparam int IDX_LOGIC   = 4;
    localparam int IDX_SHIFT   = 5;
    localparam int IDX_COMPARE = 6;
    localparam int IDX_BRANCH  = 7;
    localparam int IDX_JUMP    = 8;
    localparam int IDX_SYSTEM  = 9;
    localparam int IDX_ATOMIC  = 10;
    // The elapsed-cycle word follows the last counter.
    localparam int IDX_CYCLES  = NUM_PROF_COUNTERS;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_STOP  = 2'd1,
        CMD_DUMP  = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_DUMP  = 3'd4
    } prof_state_e;

endpackage

// File: rtl/profiler_stream_tx.sv
// rtl/profiler_stream_tx.sv - single-entry registered valid/ready output stage
//
// Purpose: holds one stream word (data, index, last) and presents it on a
// valid/ready interface. A new word may be pushed when the stage is empty or
// is handing its word off in the same cycle.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push_valid_i        load a new word (only honoured while push_ready_o)
//   push_ready_o        stage can take a word this cycle
//   push_data_i/index_i/last_i  word to load
//   out_valid_o/out_ready_i     downstream handshake
//   out_data_o/index_o/last_o   held word, stable while stalled
module profiler_stream_tx #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid_i,
    output logic              push_ready_o,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic [IDX_W-1:0]  push_index_i,
    input  logic              push_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [IDX_W-1:0]  out_index_o,
    output logic              out_last_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [IDX_W-1:0]  index_q;
    logic              last_q;

    assign push_ready_o = !valid_q || out_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
        end else if (push_ready_o) begin
            valid_q <= push_valid_i;
            if (push_valid_i) begin
                data_q  <= push_data_i;
                index_q <= push_index_i;
                last_q  <= push_last_i;
            end
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_index_o = index_q;
    assign out_last_o  = last_q;

endmodule

// File: rtl/profiler_controller.sv
// rtl/profiler_controller.sv - run-control and snapshot readout sequencer for the instruction profiler
//
// Purpose: gates the profiler enable, times an optional run window, captures
// every counter plus the elapsed cycle count one cycle after enable drops
// (before the profiler's clear takes effect), and streams the snapshot out.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake, cmd_op selects START/STOP/DUMP/CLEAR
//   window_cycles            run length sampled on START, 0 = unbounded
//   counters_in              flat profiler counter bus, counter i at [i*CNT_W +: CNT_W]
//   profiler_enable          profiler enable
//   out_valid/out_ready      snapshot stream handshake
//   out_data/out_index/out_last  stream word, index and end marker
//   running, snapshot_valid  status
//   cmd_err                  one-cycle pulse for a command illegal in the current state
module profiler_controller
    import profiler_pkg::*;
#(
    parameter int NUM_COUNTERS = NUM_PROF_COUNTERS,
    parameter int CNT_W        = 32,
    parameter int IDX_W        = $clog2(NUM_COUNTERS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [CNT_W-1:0]              window_cycles,
    input  logic [NUM_COUNTERS*CNT_W-1:0] counters_in,
    output logic                          profiler_enable,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CNT_W-1:0]              out_data,
    output logic [IDX_W-1:0]              out_index,
    output logic                          out_last,
    output logic                          running,
    output logic                          snapshot_valid,
    output logic                          cmd_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COUNTERS);

    prof_state_e                          state_q, state_d;
    logic                                 enable_q, enable_d;
    logic                                 running_q, running_d;
    logic                                 err_q, err_d;
    logic                                 snap_valid_q, snap_valid_d;
    logic [CNT_W-1:0]                     cycles_q, cycles_d;
    logic [CNT_W-1:0]                     window_q, window_d;
    logic [CNT_W-1:0]                     snap_cycles_q, snap_cycles_d;
    logic [NUM_COUNTERS-1:0][CNT_W-1:0]   snap_q, snap_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;

    logic                                 cmd_fire;
    cmd_op_e                              op;
    logic                                 auto_stop;
    logic [CNT_W-1:0]                     cycles_inc;
    logic [IDX_W-1:0]                     rd_idx;
    logic [CNT_W-1:0]                     rd_word;

    logic                                 push_valid;
    logic                                 push_ready;
    logic                                 push_last;

    assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_DONE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign op        = cmd_op_e'(cmd_op);

    // Auto-stop fires in the last cycle of the window so that exactly
    // window_q cycles are spent in RUN.
    assign auto_stop  = (window_q != '0) && (cycles_q == window_q - CNT_W'(1));
    assign cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);

    // Word 0 is pushed from DONE on the DUMP command itself, so the read
    // index is forced to 0 outside DUMP.
    assign rd_idx    = (state_q == ST_DUMP) ? idx_q : '0;
    assign push_last = (rd_idx == LAST_IDX);

    always_comb begin
        rd_word = snap_cycles_q;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_word = snap_q[i];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        enable_d      = enable_q;
        err_d         = 1'b0;
        snap_valid_d  = snap_valid_q;
        cycles_d      = cycles_q;
        window_d      = window_q;
        snap_cycles_d = snap_cycles_q;
        snap_d        = snap_q;
        idx_d         = idx_q;
        push_valid    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (cmd_fire) begin
                    case (op)
                        CMD_START: begin
                            window_d     = window_cycles;
                            cycles_d     = '0;
                            snap_valid_d = 1'b0;
                            enable_d     = 1'b1;
                            state_d      = ST_RUN;
                        end
                        CMD_CLEAR: begin
                            snap_d        = '0;
                            snap_cycles_d = '0;
                            snap_valid_d  = 1'b0;
                            state_d       = ST_IDLE;
                        end
                        CMD_DUMP: begin
                            if (state_q == ST_DONE) begin
                                push_valid = 1'b1;
                                idx_d      = IDX_W'(1);
                                state_d    = ST_DUMP;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_RUN: begin
                cycles_d = cycles_inc;
                // A STOP coinciding with window expiry is a single legal stop.
                if ((cmd_fire && op == CMD_STOP) || auto_stop) begin
                    enable_d = 1'b0;
                    state_d  = ST_DRAIN;
                end
                if (cmd_fire && op != CMD_STOP) begin
                    err_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                // The profiler clears on this same edge; sampling here captures
                // the final count including the last enabled cycle.
                snap_d        = counters_in;
                snap_cycles_d = cycles_q;
                snap_valid_d  = 1'b1;
                state_d       = ST_DONE;
            end
            ST_DUMP: begin
                // Once the last word sits in the stage nothing more is pushed.
                if (push_ready && !(out_valid && out_last)) begin
                    push_valid = 1'b1;
                    if (!push_last) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                if (out_valid && out_ready && out_last) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            enable_q      <= 1'b0;
            running_q     <= 1'b0;
            err_q         <= 1'b0;
            snap_valid_q  <= 1'b0;
            cycles_q      <= '0;
            window_q      <= '0;
            snap_cycles_q <= '0;
            snap_q        <= '0;
            idx_q         <= '0;
        end else begin
            state_q       <= state_d;
            enable_q      <= enable_d;
            running_q     <= running_d;
            err_q         <= err_d;
            snap_valid_q  <= snap_valid_d;
            cycles_q      <= cycles_d;
            window_q      <= window_d;
            snap_cycles_q <= snap_cycles_d;
            snap_q        <= snap_d;
            idx_q         <= idx_d;
        end
    end

    profiler_stream_tx #(
        .DATA_W (CNT_W),
        .IDX_W  (IDX_W)
    ) u_stream_tx (
        .clk          (clk),
        .rst          (rst),
        .push_valid_i (push_valid),
        .push_ready_o (push_ready),
        .push_data_i  (rd_word),
        .push_index_i (rd_idx),
        .push_last_i  (push_last),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_index_o  (out_index),
        .out_last_o   (out_last)
    );

    assign profiler_enable = enable_q;
    assign running         = running_q;
    assign snapshot_valid  = snap_valid_q;
    assign cmd_err         = err_q;

endmodule

// File: tb/tb_profiler_controller.sv
// tb/tb_profiler_controller.sv - self-checking bench for profiler_controller
module tb_profiler_controller;
    import profiler_pkg::*;

    localparam int N  = 11;
    localparam int W  = 32;
    localparam int IW = 4;
    localparam int NW = N + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [W-1:0]  window_cycles;
    logic [N-1:0][W-1:0] prof;
    logic          profiler_enable;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_index;
    logic          out_last;
    logic          running;
    logic          snapshot_valid;
    logic          cmd_err;

    always #5 clk = ~clk;

    profiler_controller dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .window_cycles   (window_cycles),
        .counters_in     (prof),
        .profiler_enable (profiler_enable),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_index       (out_index),
        .out_last        (out_last),
        .running         (running),
        .snapshot_valid  (snapshot_valid),
        .cmd_err         (cmd_err)
    );

    // Profiler stand-in: counts issued instructions while enabled, clears otherwise.
    logic       issue_vld;
    logic [3:0] issue_op;
    always @(posedge clk or posedge rst) begin
        if (rst) prof <= '0;
        else if (!profiler_enable) prof <= '0;
        else if (issue_vld) prof[issue_op] <= prof[issue_op] + 1;
    end

    int total  = 0;
    int passed = 0;

    // Reference: instructions issued and cycles elapsed while the run is active.
    int exp_cnt [N];
    int exp_cyc;

    logic [W-1:0]  got_data [NW];
    logic [IW-1:0] got_idx  [NW];
    logic          got_last [NW];
    int got_n, word_errs, stall_viol, busy_viol, valid_cycles;
    bit timed_out, first_valid;
    logic [W-1:0] save_data [NW];

    task automatic tick();
        if (running === 1'b1) begin
            exp_cyc++;
            if (issue_vld) exp_cnt[issue_op]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        exp_cyc = 0;
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] win);
        cmd_valid     = 1'b1;
        cmd_op        = op;
        window_cycles = win;
        tick();
        cmd_valid     = 1'b0;
    endtask

    task automatic run_until_stop(input bit rand_issue);
        for (int c = 0; c < 200 && running === 1'b1; c++) begin
            if (rand_issue) begin
                issue_vld = 1'($urandom_range(0, 1));
                issue_op  = 4'($urandom_range(0, N - 1));
            end
            tick();
        end
        issue_vld = 1'b0;
    endtask

    // Issues DUMP, collects the stream and scores it against the reference.
    task automatic dump_collect(input bit rand_ready);
        bit done = 0;
        bit held = 0;
        logic [W-1:0] h_data = '0;
        logic [IW-1:0] h_idx = '0;
        logic h_last = 1'b0;
        got_n = 0; word_errs = 0; stall_viol = 0; busy_viol = 0; valid_cycles = 0;
        send(2'(CMD_DUMP), '0);
        first_valid = (out_valid === 1'b1);
        for (int c = 0; c < 400 && !done; c++) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid === 1'b1) begin
                valid_cycles++;
                if (cmd_ready !== 1'b0) busy_viol++;
                if (held && (out_data !== h_data || out_index !== h_idx || out_last !== h_last))
                    stall_viol++;
                if (out_ready) begin
                    if (got_n < NW) begin
                        got_data[got_n] = out_data;
                        got_idx[got_n]  = out_index;
                        got_last[got_n] = out_last;
                    end
                    got_n++;
                    if (out_last) done = 1;
                    held = 0;
                end else begin
                    held = 1; h_data = out_data; h_idx = out_index; h_last = out_last;
                end
            end
            tick();
        end
        out_ready = 1'b0;
        timed_out = !done;
        if (got_n != NW) word_errs++;
        for (int i = 0; i < NW && i < got_n; i++) begin
            logic [W-1:0] e;
            e = (i < N) ? W'(exp_cnt[i]) : W'(exp_cyc);
            if (got_idx[i] !== IW'(i) || got_last[i] !== (i == N) || got_data[i] !== e)
                word_errs++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 0; cmd_op = 0; window_cycles = 0;
        out_ready = 0; issue_vld = 0; issue_op = 0;
        clear_exp();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        total++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); else passed++;
        total++; if ({out_valid, running, snapshot_valid, profiler_enable, cmd_err, out_last} !== 6'b0)
            $display("FAIL reset_flags got %b want 000000", {out_valid, running, snapshot_valid, profiler_enable, cmd_err, out_last}); else passed++;
        total++; if (out_data !== '0 || out_index !== '0) $display("FAIL reset_data got %0h/%0d want 0/0", out_data, out_index); else passed++;
    endtask

    task automatic test_unbounded();
        clear_exp();
        send(2'(CMD_START), '0);
        total++; if (running !== 1'b1 || profiler_enable !== 1'b1) $display("FAIL start_run got %b%b want 11", running, profiler_enable); else passed++;
        for (int k = 0; k < 8; k++) begin
            issue_vld = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            issue_vld = 1'b1;
            issue_op  = (k < 5) ? 4'(IDX_ADD) : 4'(IDX_LOAD);
            tick();
        end
        issue_vld = 1'b0;
        tick();
        send(2'(CMD_STOP), '0);
        total++; if (cmd_ready !== 1'b0 || profiler_enable !== 1'b0) $display("FAIL drain_ready got %b%b want 00", cmd_ready, profiler_enable); else passed++;
        tick();
        total++; if (snapshot_valid !== 1'b1) $display("FAIL snap_valid got %b want 1", snapshot_valid); else passed++;
        dump_collect(1'b0);
        total++; if (timed_out || !first_valid) $display("FAIL unb_dump_timing got to=%b first=%b want 0 1", timed_out, first_valid); else passed++;
        total++; if (word_errs !== 0) $display("FAIL unb_words got %0d errors want 0", word_errs); else passed++;
        total++; if (got_data[IDX_LOAD] !== 3 || got_data[IDX_ADD] !== 5) $display("FAIL unb_counts got load=%0d add=%0d want 3 5", got_data[IDX_LOAD], got_data[IDX_ADD]); else passed++;
        total++; if (valid_cycles !== NW) $display("FAIL unb_consecutive got %0d want %0d", valid_cycles, NW); else passed++;
        total++; if (out_valid !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL unb_after got %b%b want 01", out_valid, cmd_ready); else passed++;
    endtask

    task automatic test_windowed();
        clear_exp();
        issue_vld = 1'b1; issue_op = 4'(IDX_ADD);
        send(2'(CMD_START), 32'd10);
        run_until_stop(1'b0);
        total++; if (exp_cyc !== 10) $display("FAIL win_run_cycles got %0d want 10", exp_cyc); else passed++;
        total++; if (profiler_enable !== 1'b0) $display("FAIL win_enable got %b want 0", profiler_enable); else passed++;
        tick();
        dump_collect(1'b0);
        total++; if (word_errs !== 0) $display("FAIL win_words got %0d errors want 0", word_errs); else passed++;
        total++; if (got_data[IDX_ADD] !== 10 || got_data[IDX_CYCLES] !== 10) $display("FAIL win_values got add=%0d cyc=%0d want 10 10", got_data[IDX_ADD], got_data[IDX_CYCLES]); else passed++;
    endtask

    task automatic test_window_one();
        clear_exp();
        send(2'(CMD_START), 32'd1);
        run_until_stop(1'b1);
        total++; if (exp_cyc !== 1) $display("FAIL win1_run_cycles got %0d want 1", exp_cyc); else passed++;
        tick();
        dump_collect(1'b0);
        total++; if (word_errs !== 0) $display("FAIL win1_words got %0d errors want 0", word_errs); else passed++;
    endtask

    task automatic test_backpressure();
        int diffs = 0;
        clear_exp();
        send(2'(CMD_START), W'($urandom_range(15, 40)));
        run_until_stop(1'b1);
        tick();
        dump_collect(1'b1);
        total++; if (timed_out || word_errs !== 0) $display("FAIL bp_words got to=%b errors=%0d want 0 0", timed_out, word_errs); else passed++;
        total++; if (stall_viol !== 0) $display("FAIL bp_stable got %0d changes want 0", stall_viol); else passed++;
        total++; if (busy_viol !== 0) $display("FAIL bp_cmd_ready got %0d high want 0", busy_viol); else passed++;
        for (int i = 0; i < NW; i++) save_data[i] = got_data[i];
        dump_collect(1'b1);
        for (int i = 0; i < NW; i++) if (got_data[i] !== save_data[i]) diffs++;
        total++; if (diffs !== 0 || word_errs !== 0) $display("FAIL bp_repeat got %0d diffs %0d errors want 0 0", diffs, word_errs); else passed++;
    endtask

    task automatic test_illegal();
        clear_exp();
        send(2'(CMD_START), '0);
        run_partial();
        send(2'(CMD_DUMP), '0);
        total++; if (cmd_err !== 1'b1 || running !== 1'b1) $display("FAIL ill_dump_run got err=%b run=%b want 1 1", cmd_err, running); else passed++;
        tick();
        total++; if (cmd_err !== 1'b0) $display("FAIL ill_pulse_width got %b want 0", cmd_err); else passed++;
        send(2'(CMD_START), 32'd2);
        total++; if (cmd_err !== 1'b1 || running !== 1'b1) $display("FAIL ill_start_run got err=%b run=%b want 1 1", cmd_err, running); else passed++;
        run_partial();
        send(2'(CMD_STOP), '0);
        total++; if (cmd_err !== 1'b0 || cmd_ready !== 1'b0) $display("FAIL ill_stop_ok got err=%b rdy=%b want 0 0", cmd_err, cmd_ready); else passed++;
        tick();
        dump_collect(1'b0);
        total++; if (word_errs !== 0 || busy_viol !== 0) $display("FAIL ill_snapshot got errors=%0d busy=%0d want 0 0", word_errs, busy_viol); else passed++;
        send(2'(CMD_STOP), '0);
        total++; if (cmd_err !== 1'b1 || snapshot_valid !== 1'b1) $display("FAIL ill_stop_done got err=%b sv=%b want 1 1", cmd_err, snapshot_valid); else passed++;
        send(2'(CMD_CLEAR), '0);
        total++; if (cmd_err !== 1'b0 || snapshot_valid !== 1'b0) $display("FAIL clear got err=%b sv=%b want 0 0", cmd_err, snapshot_valid); else passed++;
        send(2'(CMD_STOP), '0);
        total++; if (cmd_err !== 1'b1) $display("FAIL ill_stop_idle got %b want 1", cmd_err); else passed++;
        send(2'(CMD_DUMP), '0);
        total++; if (cmd_err !== 1'b1 || out_valid !== 1'b0) $display("FAIL ill_dump_idle got err=%b v=%b want 1 0", cmd_err, out_valid); else passed++;
        tick();
    endtask

    task automatic run_partial();
        repeat ($urandom_range(3, 8)) begin
            issue_vld = 1'($urandom_range(0, 1));
            issue_op  = 4'($urandom_range(0, N - 1));
            tick();
        end
        issue_vld = 1'b0;
    endtask

    task automatic test_simultaneous();
        int w;
        clear_exp();
        w = $urandom_range(3, 12);
        send(2'(CMD_START), W'(w));
        repeat (w - 1) begin
            issue_vld = 1'($urandom_range(0, 1));
            issue_op  = 4'($urandom_range(0, N - 1));
            tick();
        end
        send(2'(CMD_STOP), '0);
        total++; if (cmd_err !== 1'b0 || running !== 1'b0) $display("FAIL sim_stop got err=%b run=%b want 0 0", cmd_err, running); else passed++;
        tick();
        tick();
        total++; if (cmd_ready !== 1'b1 || snapshot_valid !== 1'b1 || cmd_err !== 1'b0) $display("FAIL sim_single_drain got rdy=%b sv=%b err=%b want 1 1 0", cmd_ready, snapshot_valid, cmd_err); else passed++;
        dump_collect(1'b0);
        total++; if (word_errs !== 0 || got_data[IDX_CYCLES] !== W'(w)) $display("FAIL sim_snapshot got errors=%0d cyc=%0d want 0 %0d", word_errs, got_data[IDX_CYCLES], w); else passed++;
    endtask

    task automatic test_reset_mid_dump();
        clear_exp();
        send(2'(CMD_START), '0);
        run_partial();
        send(2'(CMD_STOP), '0);
        tick();
        send(2'(CMD_DUMP), '0);
        out_ready = 1'b1;
        repeat (4) tick();
        total++; if (out_valid !== 1'b1 || out_index !== 4'd4) $display("FAIL rmd_progress got v=%b idx=%0d want 1 4", out_valid, out_index); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || snapshot_valid !== 1'b0 || profiler_enable !== 1'b0) $display("FAIL rmd_async got v=%b sv=%b en=%b want 0 0 0", out_valid, snapshot_valid, profiler_enable); else passed++;
        total++; if (cmd_ready !== 1'b1 || running !== 1'b0) $display("FAIL rmd_idle got rdy=%b run=%b want 1 0", cmd_ready, running); else passed++;
        out_ready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        send(2'(CMD_DUMP), '0);
        total++; if (cmd_err !== 1'b1 || out_valid !== 1'b0) $display("FAIL rmd_dump_err got err=%b v=%b want 1 0", cmd_err, out_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_unbounded();
        test_windowed();
        test_window_one();
        test_backpressure();
        test_illegal();
        test_simultaneous();
        test_reset_mid_dump();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
